// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
// Scans the shared 7-segment cathode bus across eight anodes. Digit writes go
// to a shadow bank. A commit copies the shadow bank into the displayed
// (active) bank at a frame boundary, so a frame never mixes old and new digits.
// Each digit slot starts with a blanking gap that suppresses ghosting.
module ssd_scan_controller #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic [7:0] digit_en,
    output logic       commit_pending,
    output logic       frame_tick,
    output logic [7:0] An,
    output logic [6:0] Cath,
    output logic       Dp
);

    localparam int            CW        = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [7:0]    BLANK_DIG = 8'h40;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shadow     [8];
    logic [7:0]    active     [8];
    logic [7:0]    shadow_nxt [8];
    logic          pending;
    logic          boundary;
    logic          do_copy;

    logic [7:0]    cur_digit;
    logic          lit;
    logic [7:0]    an_nxt;
    logic [6:0]    cath_nxt;
    logic          dp_nxt;

    // Hex digit to active-low segments, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    seg_decode = 7'b0000001;
            4'h1:    seg_decode = 7'b1001111;
            4'h2:    seg_decode = 7'b0010010;
            4'h3:    seg_decode = 7'b0000110;
            4'h4:    seg_decode = 7'b1001100;
            4'h5:    seg_decode = 7'b0100100;
            4'h6:    seg_decode = 7'b0100000;
            4'h7:    seg_decode = 7'b0001111;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0000100;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b1100000;
            4'hC:    seg_decode = 7'b0110001;
            4'hD:    seg_decode = 7'b1000010;
            4'hE:    seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    assign boundary       = (idx == 3'd7) && (cnt == CNT_LAST);
    assign do_copy        = boundary && (pending || commit);
    assign commit_pending = pending;

    // Shadow bank as it will look after this edge; a copy on the boundary
    // must include a write landing in the same cycle.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            shadow_nxt[i] = shadow[i];
        end
        if (wr_en) begin
            shadow_nxt[wr_addr] = wr_data;
        end
    end

    // Slot counter and digit index.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow bank writes and atomic shadow-to-active copy.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= BLANK_DIG;
                active[i] <= BLANK_DIG;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (do_copy) begin
                    active[i] <= shadow_nxt[i];
                end
            end
        end
    end

    // Commit request latch and frame boundary pulse.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (do_copy) begin
                pending <= 1'b0;
            end else if (commit) begin
                pending <= 1'b1;
            end
        end
    end

    // Next anode/cathode values from the current slot position.
    always_comb begin
        cur_digit = active[idx];
        lit       = (cnt >= CNT_BLANK) && digit_en[idx] && !cur_digit[6];
        an_nxt    = 8'hFF;
        cath_nxt  = 7'h7F;
        dp_nxt    = 1'b1;
        if (lit) begin
            an_nxt[idx] = 1'b0;
            cath_nxt    = seg_decode(cur_digit[3:0]);
            dp_nxt      = ~cur_digit[7];
        end
    end

    // Output register; the pins lag the slot state by one clock.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            An   <= 8'hFF;
            Cath <= 7'h7F;
            Dp   <= 1'b1;
        end else begin
            An   <= an_nxt;
            Cath <= cath_nxt;
            Dp   <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// A frame is 64 clocks; sample j of a frame shows the pins for idx=j/8,
// cnt=j%8, and frame_tick is high at sample 63.
module tb_ssd_scan_controller;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       commit = 1'b0;
    logic [7:0] digit_en = 8'hFF;
    logic       commit_pending;
    logic       frame_tick;
    logic [7:0] An;
    logic [6:0] Cath;
    logic       Dp;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] exp_act [8];

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    ssd_scan_controller #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .digit_en(digit_en),
        .commit_pending(commit_pending), .frame_tick(frame_tick),
        .An(An), .Cath(Cath), .Dp(Dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sh(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 200);
        vectors++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame_tick not seen within %0d cycles", name, n);
        end
    endtask

    // 128 clocks of blank output with frame_tick at samples 63 and 127.
    task automatic blank_run(input string name, input bit do_write);
        for (int k = 0; k < 128; k++) begin
            if (do_write && k == 0) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h03;
            end
            tick();
            wr_en = 1'b0;
            vectors += 5;
            if (An !== 8'hFF) begin
                errors++; $display("FAIL %s An k=%0d: got %h want ff", name, k, An);
            end
            if (Cath !== 7'h7F) begin
                errors++; $display("FAIL %s Cath k=%0d: got %b want 1111111", name, k, Cath);
            end
            if (Dp !== 1'b1) begin
                errors++; $display("FAIL %s Dp k=%0d: got %b want 1", name, k, Dp);
            end
            if (frame_tick !== ((k % 64) == 63)) begin
                errors++; $display("FAIL %s frame_tick k=%0d: got %b want %b", name, k, frame_tick, (k % 64) == 63);
            end
            if (commit_pending !== 1'b0) begin
                errors++; $display("FAIL %s pending k=%0d: got %b want 0", name, k, commit_pending);
            end
        end
    endtask

    // One full frame starting at idx0/cnt0, checked against exp_act.
    task automatic check_frame(input string name, input int commit_at, input int wr_at,
                               input logic [2:0] wa, input logic [7:0] wd);
        int         ix, c;
        logic [7:0] cur, e_an;
        logic [6:0] e_cath;
        logic       e_dp, lit, e_ft, e_pend;
        for (int j = 0; j < 64; j++) begin
            if (j == commit_at) commit = 1'b1;
            if (j == wr_at) begin
                wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            end
            tick();
            commit = 1'b0;
            wr_en  = 1'b0;
            ix  = j / 8;
            c   = j % 8;
            cur = exp_act[ix];
            lit = (c >= 2) && digit_en[ix] && !cur[6];
            e_an = 8'hFF;
            if (lit) e_an[ix] = 1'b0;
            e_cath = lit ? SEG[cur[3:0]] : 7'h7F;
            e_dp   = lit ? ~cur[7] : 1'b1;
            e_ft   = (j == 63);
            e_pend = (commit_at >= 0) && (j >= commit_at) && (j < 63);
            vectors += 5;
            if (An !== e_an) begin
                errors++; $display("FAIL %s An j=%0d: got %h want %h", name, j, An, e_an);
            end
            if (Cath !== e_cath) begin
                errors++; $display("FAIL %s Cath j=%0d: got %b want %b", name, j, Cath, e_cath);
            end
            if (Dp !== e_dp) begin
                errors++; $display("FAIL %s Dp j=%0d: got %b want %b", name, j, Dp, e_dp);
            end
            if (frame_tick !== e_ft) begin
                errors++; $display("FAIL %s frame_tick j=%0d: got %b want %b", name, j, frame_tick, e_ft);
            end
            if (commit_pending !== e_pend) begin
                errors++; $display("FAIL %s pending j=%0d: got %b want %b", name, j, commit_pending, e_pend);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) exp_act[i] = 8'h40;
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors += 5;
        if (An !== 8'hFF) begin errors++; $display("FAIL reset An: got %h want ff", An); end
        if (Cath !== 7'h7F) begin errors++; $display("FAIL reset Cath: got %b want 1111111", Cath); end
        if (Dp !== 1'b1) begin errors++; $display("FAIL reset Dp: got %b want 1", Dp); end
        if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset pending: got %b want 0", commit_pending); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset frame_tick: got %b want 0", frame_tick); end
        Reset = 1'b0;
        blank_run("t1_idle", 1'b0);
    endtask

    task automatic test_commit_basic();
        digit_en = 8'hFF;
        write_sh(3'd0, 8'h03);
        write_sh(3'd3, 8'h8A);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++;
        if (commit_pending !== 1'b1) begin
            errors++; $display("FAIL t2 pending after commit: got %b want 1", commit_pending);
        end
        wait_frame("t2_wait");
        vectors++;
        if (commit_pending !== 1'b0) begin
            errors++; $display("FAIL t2 pending at frame_tick: got %b want 0", commit_pending);
        end
        exp_act[0] = 8'h03;
        exp_act[3] = 8'h8A;
        check_frame("t2_frame", -1, -1, 3'd0, 8'h00);
    endtask

    task automatic test_no_commit();
        write_sh(3'd1, 8'h05);
        wait_frame("t3_wait");
        for (int f = 0; f < 3; f++) check_frame("t3_hold", -1, -1, 3'd0, 8'h00);
    endtask

    task automatic test_late_commit();
        check_frame("t4_pending", 10, -1, 3'd0, 8'h00);
        exp_act[1] = 8'h05;
        check_frame("t4_new", -1, -1, 3'd0, 8'h00);
    endtask

    task automatic test_boundary_write();
        check_frame("t5_boundary", 63, 63, 3'd2, 8'h0F);
        exp_act[2] = 8'h0F;
        check_frame("t5_new", -1, -1, 3'd0, 8'h00);
    endtask

    task automatic test_mask_and_reset();
        tick(); tick(); tick();
        vectors += 3;
        if (An !== 8'hFE) begin errors++; $display("FAIL t6 An lit: got %h want fe", An); end
        if (Cath !== 7'b0000110) begin errors++; $display("FAIL t6 Cath lit: got %b want 0000110", Cath); end
        if (Dp !== 1'b1) begin errors++; $display("FAIL t6 Dp lit: got %b want 1", Dp); end
        digit_en = 8'hFE;
        tick();
        vectors += 3;
        if (An !== 8'hFF) begin errors++; $display("FAIL t6 An masked: got %h want ff", An); end
        if (Cath !== 7'h7F) begin errors++; $display("FAIL t6 Cath masked: got %b want 1111111", Cath); end
        if (Dp !== 1'b1) begin errors++; $display("FAIL t6 Dp masked: got %b want 1", Dp); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++;
        if (commit_pending !== 1'b1) begin errors++; $display("FAIL t6 pending: got %b want 1", commit_pending); end
        repeat (20) tick();
        #2;
        Reset = 1'b1;
        #1;
        vectors += 4;
        if (An !== 8'hFF) begin errors++; $display("FAIL t6 reset An: got %h want ff", An); end
        if (Cath !== 7'h7F) begin errors++; $display("FAIL t6 reset Cath: got %b want 1111111", Cath); end
        if (Dp !== 1'b1) begin errors++; $display("FAIL t6 reset Dp: got %b want 1", Dp); end
        if (commit_pending !== 1'b0) begin errors++; $display("FAIL t6 reset pending: got %b want 0", commit_pending); end
        digit_en = 8'hFF;
        tick();
        Reset = 1'b0;
        // A surviving commit would expose this uncommitted write.
        blank_run("t6_after_reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_commit_basic();
        test_no_commit();
        test_late_commit();
        test_boundary_write();
        test_mask_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Time-multiplexes the board's shared 7-segment cathode bus across all 8 anodes.
- Requesters (game logic, switch readback) write digit values into a shadow bank. A commit copies the shadow bank to the active bank atomically at a frame boundary, so the display never tears.
- Inserts a blanking gap before each digit slot to suppress ghosting.
- Replaces the two-digit scan in the top level; drives An0..An7, Ca..Cg and Dp directly.

Parameters:
- DIGIT_CYCLES, 100000: clocks per digit slot (1 ms at 100 MHz). Legal range 4..2^20.
- BLANK_CYCLES, 2000: leading clocks of each slot with all anodes off. Legal range 1..DIGIT_CYCLES-2.

Ports:
- clk  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe to shadow bank
- wr_addr  in  3  digit index for the write (0 = An0)
- wr_data  in  8  digit code: [7] decimal point on, [6] blank digit, [5:4] ignored, [3:0] hex value
- commit  in  1  one-cycle request to copy shadow bank to active bank at the next frame boundary
- digit_en  in  8  per-anode enable mask; 0 forces that anode off; sampled live
- commit_pending  out  1  a commit is waiting for a frame boundary
- frame_tick  out  1  one-cycle pulse at each frame boundary
- An  out  8  anodes, active-low, An[i] drives An(i)
- Cath  out  7  {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, active-low
- Dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, active-high):
  - slot counter cnt=0, digit index idx=0.
  - All shadow and active entries = 8'h40 (blank).
  - An=8'hFF, Cath=7'h7F, Dp=1, commit_pending=0, frame_tick=0.
- Scan:
  - cnt counts 0..DIGIT_CYCLES-1, then wraps to 0 and idx increments mod 8.
  - A frame is 8*DIGIT_CYCLES clocks.
- Slot phases:
  - cnt < BLANK_CYCLES is the BLANK phase: An=8'hFF, Cath=7'h7F, Dp=1.
  - Otherwise the ON phase: An[idx]=0 only if digit_en[idx]=1 and active[idx][6]=0. All other anode bits are 1.
  - Cath = decode(active[idx][3:0]); Dp = ~active[idx][7].
  - If the anode is suppressed in ON, Cath=7'h7F and Dp=1.
- All outputs are registered, with one clock of latency from the cnt/idx state that produced them.
- Decode (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Writes:
  - wr_en writes wr_data into shadow[wr_addr] on the clock edge.
  - Writes never touch the active bank directly.
- Commit handshake:
  - commit sets a pending flag; commit_pending goes high the cycle after commit.
  - Boundary cycle = the cycle where idx=7 and cnt=DIGIT_CYCLES-1.
  - On the boundary cycle, if pending or commit is asserted: active <= shadow for all 8 entries, including any wr_en on that same cycle. Pending then clears.
  - Extra commits while pending merge; one copy occurs.
- frame_tick:
  - Registered; high exactly the one cycle after each boundary cycle.
  - This is the first cycle with idx=0, and active already holds the new bank.
  - commit_pending reads 0 in that same cycle.
- Other inputs:
  - digit_en changes take effect on the next output register update; no frame alignment.
  - Reset mid-frame aborts the scan and discards any pending commit.

Test Plan:
- DIGIT_CYCLES=8, BLANK_CYCLES=2 for all scenarios.
  1. Release Reset, no writes -> An stays 8'hFF, Cath 7'h7F and Dp 1 for 128 clocks; frame_tick pulses every 64 clocks.
  2. Write shadow[0]=8'h03, shadow[3]=8'h8A, commit, digit_en=8'hFF -> after the next frame_tick:
     - idx0 ON cycles show An=8'hFE, Cath=0000110, Dp=1.
     - idx3 ON cycles show An=8'hF7, Cath=0001000, Dp=0.
     - Each slot shows 2 blank cycles then 6 lit.
  3. Write shadow[1]=8'h05 without commit -> display unchanged for 3 frames; commit_pending stays 0.
  4. Assert commit 10 cycles into a frame -> commit_pending=1 until the boundary; frame_tick and the new values appear together; commit_pending=0 that cycle.
  5. Same-cycle wr_en(addr 2, 8'h0F) and commit on the boundary cycle -> next frame shows F on An2.
  6. Clear digit_en[0] mid-ON slot -> An0 high within 1 clock. Then assert Reset mid-frame with commit pending -> all outputs return to reset values immediately and the pending commit is discarded.
